// File: rtl/alu.sv
// Registered 4-bit ALU: MUL/SUB/AND/XOR of a 4-bit A with a zero-extended 2-bit B.
// Result and Z/N/C/V flags are loaded on every rising clk edge.
module alu (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [1:0] B,
   input  logic [1:0] sel,
   output logic [3:0] Y,
   output logic       Z,
   output logic       N,
   output logic       C,
   output logic       V
);

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   logic [3:0] bx;
   logic [3:0] pp0, pp1;
   logic [5:0] prod;
   logic [3:0] mul_cy;
   logic [3:0] diff;
   logic [4:0] sub_bw;

   logic [3:0] res_y;
   logic       res_c, res_v;

   assign bx  = {2'b00, B};
   assign pp0 = A & {4{B[0]}};
   assign pp1 = A & {4{B[1]}};

   // 4x2 array multiplier: one ripple row adds the B[1] partial product shifted by one.
   always_comb begin
      prod      = '0;
      mul_cy    = '0;
      prod[0]   = pp0[0];
      for (int i = 1; i < 4; i++) begin
         prod[i]  = pp0[i] ^ pp1[i-1] ^ mul_cy[i-1];
         mul_cy[i] = (pp0[i] & pp1[i-1]) | (mul_cy[i-1] & (pp0[i] ^ pp1[i-1]));
      end
      prod[4] = pp1[3] ^ mul_cy[3];
      prod[5] = pp1[3] & mul_cy[3];
   end

   // Ripple-borrow subtractor; sub_bw[4] is the borrow out (A < Bx unsigned).
   always_comb begin
      diff      = '0;
      sub_bw    = '0;
      for (int i = 0; i < 4; i++) begin
         diff[i]     = A[i] ^ bx[i] ^ sub_bw[i];
         sub_bw[i+1] = (~A[i] & bx[i]) | (~(A[i] ^ bx[i]) & sub_bw[i]);
      end
   end

   // NOTE: every output of this block is given a default first so no latch is inferred.
   always_comb begin
      res_y = '0;
      res_c = 1'b0;
      res_v = 1'b0;
      case (sel)
         OP_MUL: begin
            res_y = prod[3:0];
            res_c = |prod[5:4];
            res_v = |prod[5:4];
         end
         OP_SUB: begin
            res_y = diff;
            res_c = sub_bw[4];
            // Bx is never negative, so overflow only when a negative A wraps positive.
            res_v = A[3] & ~diff[3];
         end
         OP_AND:  res_y = A & bx;
         OP_XOR:  res_y = A ^ bx;
         default: res_y = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Y <= '0;
         Z <= 1'b0;
         N <= 1'b0;
         C <= 1'b0;
         V <= 1'b0;
      end else begin
         Y <= res_y;
         Z <= (res_y == 4'b0000);
         N <= res_y[3];
         C <= res_c;
         V <= res_v;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver queues hand-computed results, the monitor
// pops one per clock edge and compares against the registered outputs.
module tb_alu;

   logic       clk;
   logic       rst_n;
   logic [3:0] A;
   logic [1:0] B;
   logic [1:0] sel;
   logic [3:0] Y;
   logic       Z, N, C, V;

   typedef struct {
      logic [3:0] y;
      logic [3:0] zncv;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   alu dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .B    (B),
      .sel  (sel),
      .Y    (Y),
      .Z    (Z),
      .N    (N),
      .C    (C),
      .V    (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got y=%b zncv=%b, expected y=%b zncv=%b",
                  name, got[7:4], got[3:0], want[7:4], want[3:0]);
      end
   endtask

   // Apply inputs away from the edge and queue the result the next edge must produce.
   task automatic drive(input logic [3:0] a, input logic [1:0] b, input logic [1:0] s,
                        input logic [3:0] ey, input logic [3:0] ezncv, input string name);
      exp_t e;
      @(negedge clk);
      A = a;
      B = b;
      sel = s;
      e.y = ey;
      e.zncv = ezncv;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: one result per rising edge while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, {Y, Z, N, C, V}, {e.y, e.zncv});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      A = 4'b1111;
      B = 2'b11;
      sel = 2'b00;
      #2;
      check("por_reset", {Y, Z, N, C, V}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Load a MUL result, then assert reset mid-cycle and confirm it clears without a clock.
      drive(4'b1111, 2'b11, 2'b00, 4'b1101, 4'b0111, "pre_reset_mul");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_reset_clear", {Y, Z, N, C, V}, 8'h00);
      @(posedge clk);
      #1;
      check("reset_held_over_edge", {Y, Z, N, C, V}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b1111, 2'b11, 2'b00, 4'b1101, 4'b0111, "post_reset_mul");

      // A=0101 B=01 sel sweep
      drive(4'b0101, 2'b01, 2'b00, 4'b0101, 4'b0000, "a5b1_mul");
      drive(4'b0101, 2'b01, 2'b01, 4'b0100, 4'b0000, "a5b1_sub");
      drive(4'b0101, 2'b01, 2'b10, 4'b0001, 4'b0000, "a5b1_and");
      drive(4'b0101, 2'b01, 2'b11, 4'b0100, 4'b0000, "a5b1_xor");

      // A=1111 B=11
      drive(4'b1111, 2'b11, 2'b00, 4'b1101, 4'b0111, "aFb3_mul");
      drive(4'b1111, 2'b11, 2'b01, 4'b1100, 4'b0100, "aFb3_sub");
      drive(4'b1111, 2'b11, 2'b10, 4'b0011, 4'b0000, "aFb3_and");
      drive(4'b1111, 2'b11, 2'b11, 4'b1100, 4'b0100, "aFb3_xor");

      // All-zero operands: zero flag on every op
      for (int s = 0; s < 4; s++)
         drive(4'b0000, 2'b00, s[1:0], 4'b0000, 4'b1000, $sformatf("zero_sel%0d", s));

      // SUB boundaries
      drive(4'b0001, 2'b10, 2'b01, 4'b1111, 4'b0110, "sub_borrow");
      drive(4'b1000, 2'b01, 2'b01, 4'b0111, 4'b0001, "sub_overflow");
      drive(4'b0010, 2'b10, 2'b01, 4'b0000, 4'b1000, "sub_zero");

      // Latency: sel changes each cycle with A=0110 B=10
      drive(4'b0110, 2'b10, 2'b00, 4'b1100, 4'b0100, "lat_mul");
      drive(4'b0110, 2'b10, 2'b01, 4'b0100, 4'b0000, "lat_sub");
      drive(4'b0110, 2'b10, 2'b10, 4'b0010, 4'b0000, "lat_and");
      drive(4'b0110, 2'b10, 2'b11, 4'b0100, 4'b0000, "lat_xor");

      // Mid-cycle input change must not disturb the registered XOR result.
      @(posedge clk);
      #3;
      A = 4'b1111;
      sel = 2'b00;
      #1;
      check("hold_between_edges", {Y, Z, N, C, V}, {4'b0100, 4'b0000});

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
